bsg_blackparrot_mc_link_arbiter: RTL

- Shares one manycore request link between num_req_p BlackParrot tile-node requesters, e.g. the two tile nodes of a unicore pod contending for a single vertical egress link.
- Arbitrates round-robin and registers the winning packet in a one-entry output stage.
- Bounds outstanding requests with a credit counter.
- Records the requester ID of each issued packet in an in-order tag FIFO, so that each returning response goes back to the requester that issued it.

---
 rtl/bsg_blackparrot_mc_link_arbiter_if.sv | 33 +++
 rtl/bsg_blackparrot_mc_link_arbiter.sv | 105 ++++++++++
 2 files changed

// File: rtl/bsg_blackparrot_mc_link_arbiter_if.sv
// Handshake bundle between BlackParrot requesters, the shared manycore link and the arbiter.
// The arbiter uses the slave modport; whoever drives requests and the link uses master.
interface bsg_blackparrot_mc_link_arbiter_if #(
  parameter int unsigned num_req_p   = 2,
  parameter int unsigned pkt_width_p = 128,
  parameter int unsigned rsp_width_p = 64
);
  logic [num_req_p-1:0]             req_v_i;
  logic [num_req_p*pkt_width_p-1:0] req_data_i;
  logic [num_req_p-1:0]             req_ready_o;

  logic                             out_v_o;
  logic [pkt_width_p-1:0]           out_data_o;
  logic                             out_ready_i;

  logic                             rsp_v_i;
  logic [rsp_width_p-1:0]           rsp_data_i;
  logic                             rsp_ready_o;

  logic [num_req_p-1:0]             rsp_v_o;
  logic [rsp_width_p-1:0]           rsp_data_o;
  logic [num_req_p-1:0]             rsp_ready_i;

  modport slave (
    input  req_v_i, req_data_i, out_ready_i, rsp_v_i, rsp_data_i, rsp_ready_i,
    output req_ready_o, out_v_o, out_data_o, rsp_ready_o, rsp_v_o, rsp_data_o
  );

  modport master (
    output req_v_i, req_data_i, out_ready_i, rsp_v_i, rsp_data_i, rsp_ready_i,
    input  req_ready_o, out_v_o, out_data_o, rsp_ready_o, rsp_v_o, rsp_data_o
  );
endinterface

// File: rtl/bsg_blackparrot_mc_link_arbiter.sv
// Round-robin arbiter sharing one manycore request link among BlackParrot requesters, with a
// credit limit and an in-order tag FIFO that steers each response back to its issuer.
module bsg_blackparrot_mc_link_arbiter #(
  parameter int unsigned num_req_p   = 2,
  parameter int unsigned pkt_width_p = 128,
  parameter int unsigned rsp_width_p = 64,
  parameter int unsigned max_out_p   = 8,
  localparam int unsigned cnt_w_lp   = $clog2(max_out_p + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  bsg_blackparrot_mc_link_arbiter_if.slave link_if,
  output logic [cnt_w_lp-1:0]   outstanding_o,
  output logic                  err_o
);
  localparam int unsigned id_w_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int unsigned aw_lp   = $clog2(max_out_p);

  logic                   out_v_q;
  logic [pkt_width_p-1:0] out_data_q;
  logic [id_w_lp-1:0]     rr_ptr_q;
  logic [id_w_lp-1:0]     tag_mem_q [max_out_p];
  logic [aw_lp-1:0]       wr_ptr_q, rd_ptr_q;
  logic [cnt_w_lp-1:0]    cnt_q, cnt_d;
  logic                   err_q;

  logic                   fifo_empty, can_issue, issue, pop;
  logic                   grant_found;
  logic [id_w_lp-1:0]     grant_id, head_id;
  logic [id_w_lp:0]       cand;
  logic [pkt_width_p-1:0] grant_pkt;

  assign fifo_empty = (cnt_q == '0);
  // The credit check uses the pre-pop count, so a response never frees a slot in the same cycle.
  assign can_issue  = (!out_v_q | link_if.out_ready_i) & (cnt_q < cnt_w_lp'(max_out_p));
  assign head_id    = tag_mem_q[rd_ptr_q];

  always_comb begin
    grant_found = 1'b0;
    grant_id    = rr_ptr_q;
    cand        = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      cand = {1'b0, rr_ptr_q} + (id_w_lp + 1)'(i);
      if (cand >= (id_w_lp + 1)'(num_req_p)) cand = cand - (id_w_lp + 1)'(num_req_p);
      if (!grant_found && link_if.req_v_i[cand[id_w_lp-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = cand[id_w_lp-1:0];
      end
    end
  end

  assign issue = can_issue & grant_found;

  always_comb begin
    grant_pkt           = '0;
    link_if.req_ready_o = '0;
    link_if.rsp_v_o     = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      if (grant_id == id_w_lp'(i)) begin
        grant_pkt              = link_if.req_data_i[i*pkt_width_p +: pkt_width_p];
        link_if.req_ready_o[i] = issue;
      end
      if (head_id == id_w_lp'(i)) link_if.rsp_v_o[i] = link_if.rsp_v_i & !fifo_empty;
    end
  end

  assign link_if.rsp_ready_o = !fifo_empty & link_if.rsp_ready_i[head_id];
  assign link_if.rsp_data_o  = link_if.rsp_data_i;
  assign pop                 = link_if.rsp_v_i & link_if.rsp_ready_o;
  assign cnt_d               = cnt_q + cnt_w_lp'(issue) - cnt_w_lp'(pop);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_v_q    <= 1'b0;
      out_data_q <= '0;
      rr_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (issue) begin
        out_v_q    <= 1'b1;
        out_data_q <= grant_pkt;
        rr_ptr_q   <= (grant_id == id_w_lp'(num_req_p - 1)) ? '0 : grant_id + 1'b1;
        wr_ptr_q   <= (wr_ptr_q == aw_lp'(max_out_p - 1)) ? '0 : wr_ptr_q + 1'b1;
      end else if (link_if.out_ready_i) begin
        out_v_q <= 1'b0;
      end
      if (pop) rd_ptr_q <= (rd_ptr_q == aw_lp'(max_out_p - 1)) ? '0 : rd_ptr_q + 1'b1;
      if (link_if.rsp_v_i & fifo_empty) err_q <= 1'b1;
    end
  end

  // Tag storage needs no reset: occupancy is tracked entirely by the count and pointers.
  always_ff @(posedge clk_i) begin
    if (issue) tag_mem_q[wr_ptr_q] <= grant_id;
  end

  assign link_if.out_v_o    = out_v_q;
  assign link_if.out_data_o = out_data_q;
  assign outstanding_o      = cnt_q;
  assign err_o              = err_q;
endmodule
